range_burst_tx: RTL

Store-and-forward burst transmitter that drives the go/finish/data_in sample protocol consumed by the range finder. An upstream writer pushes samples through a ready/valid port, with the last sample of each burst marked. Each complete burst is buffered, then replayed as one contiguous, gap-free burst: `go` on the first sample and `finish` on the last. It sits directly in front of the range finder and feeds it test or sensor data.

---
 rtl/range_burst_tx_if.sv | 7 +
 rtl/range_burst_tx.sv | 85 ++++++++
 2 files changed

// File: rtl/range_burst_tx_if.sv
// range_burst_tx_if: writer ready/valid port plus go/finish/data_out sample stream
interface range_burst_tx_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] wr_data, data_out;
  logic wr_valid, wr_last, wr_ready, go, finish, busy, drop_err;
  modport master(output wr_data, wr_valid, wr_last, input wr_ready, data_out, go, finish, busy, drop_err);
  modport slave(input wr_data, wr_valid, wr_last, output wr_ready, data_out, go, finish, busy, drop_err);
endinterface

// File: rtl/range_burst_tx.sv
// range_burst_tx: store-and-forward burst FIFO replayed as gap-free go/finish bursts; RANGE_BURST_TX_SINGLE_EN allows one-word bursts
module range_burst_tx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic clock,
  input logic reset,
  range_burst_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic [1:0] {IDLE, MID, GAP} state_t;
  state_t st;
  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, open_start, open_len;
  logic [CW-1:0] count, count_n, complete;
  logic rep, acc, drop, wen, pop, start;
  logic [WIDTH:0] head;
  always_comb begin
    acc = bus.wr_valid & bus.wr_ready;
`ifdef RANGE_BURST_TX_SINGLE_EN
    drop = acc & !bus.wr_last & (open_len == AW'(DEPTH - 1));
`else
    drop = acc & (bus.wr_last ? open_len == '0 : open_len == AW'(DEPTH - 1));
`endif
    wen = acc & !drop;
    head = mem[rp];
    start = st == IDLE && complete != '0;
    pop = start | (st == MID & !rep);
    count_n = count + CW'(wen) - CW'(pop) - (drop ? CW'(open_len) : '0);
  end
  always_ff @(posedge clock)
    if (wen) mem[wp] <= {bus.wr_last, bus.wr_data};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      open_start <= '0;
      open_len <= '0;
      count <= '0;
      complete <= '0;
      rep <= 1'b0;
      st <= IDLE;
      bus.wr_ready <= 1'b1;
      bus.data_out <= '0;
      bus.go <= 1'b0;
      bus.finish <= 1'b0;
      bus.busy <= 1'b0;
      bus.drop_err <= 1'b0;
    end else begin
      count <= count_n;
      bus.wr_ready <= count_n != CW'(DEPTH);
      bus.drop_err <= drop;
      wp <= drop ? open_start : wp + AW'(wen);
      open_len <= drop ? '0 : wen ? (bus.wr_last ? '0 : open_len + AW'(1)) : open_len;
      if (wen & bus.wr_last) open_start <= wp + AW'(1);
      complete <= complete + CW'(wen & bus.wr_last) - CW'(start);
      rp <= rp + AW'(pop);
      case (st)
        IDLE: begin
          bus.go <= start;
          bus.finish <= 1'b0;
          bus.data_out <= start ? head[WIDTH-1:0] : '0;
          bus.busy <= start;
          rep <= start & head[WIDTH];
          if (start) st <= MID;
        end
        MID: begin
          // a replayed single word repeats its sample with finish instead of popping again
          bus.go <= 1'b0;
          bus.finish <= rep | head[WIDTH];
          bus.data_out <= rep ? bus.data_out : head[WIDTH-1:0];
          rep <= 1'b0;
          if (rep | head[WIDTH]) st <= GAP;
        end
        GAP: begin
          bus.go <= 1'b0;
          bus.finish <= 1'b0;
          bus.data_out <= '0;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
endmodule
